// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, master state encoding and frame width.
// Also imported by slave-side benches.
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_HOLD,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_t;

  localparam int unsigned FRAME_W = 10;

endpackage

// File: rtl/spi_shift_tx.sv
// Parallel-load, MSB-first serializer; msb_o presents the current bit.
module spi_shift_tx #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         msb_o
);
  logic [W-1:0] sreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sreg_q[W-1];
endmodule

// File: rtl/spi_master.sv
// SPI master: frames {op, byte} commands; read-data ops add a wait and an 8-bit LSB-first receive.
// Optional macro SPI_MASTER_SEQ_CHK_EN rejects read-data ops not preceded by a completed read-address op.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT    = 3,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err
);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_t        op_q;
  logic       load, seq_block, tx_msb, last_rx;
  logic [7:0] rx_q, rsp_data_q;
  logic       rsp_valid_q;

  spi_shift_tx #(.W(FRAME_W)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .data_i ({cmd_op, ((op_t'(cmd_op) == RD_DATA) ? 8'h00 : cmd_data)}),
    .shift_i(state_q == ST_SHIFT),
    .msb_o  (tx_msb)
  );

  assign last_rx = (state_q == ST_RECV) && (cnt_q == 4'd7);

  // Counter restarts from zero on every state entry; each phase ends on its own terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_valid && !seq_block) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: if (cnt_q == 4'd1) begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: if (cnt_q == 4'(FRAME_W - 1)) begin
        state_d = (op_q == RD_DATA) ? ST_WAIT : ST_HOLD;
        cnt_d   = '0;
      end
      ST_HOLD: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_WAIT: if (cnt_q == 4'(RD_WAIT - 1)) begin
        state_d = ST_RECV;
        cnt_d   = '0;
      end
      ST_RECV: if (last_rx) begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_GAP: if (cnt_q == 4'(GAP_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    MOSI = 1'b0;
    if (state_q == ST_START)      MOSI = op_q[1];
    else if (state_q == ST_SHIFT) MOSI = tx_msb;
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign SS_n      = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= WR_ADDR;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= last_rx;
      if (load) op_q <= op_t'(cmd_op);
      if (state_q == ST_RECV) rx_q <= {MISO, rx_q[7:1]};
      if (last_rx) rsp_data_q <= {MISO, rx_q[7:1]};
    end
  end

`ifdef SPI_MASTER_SEQ_CHK_EN
  logic rd_flag_q, err_q;

  assign seq_block = (op_t'(cmd_op) == RD_DATA) && !rd_flag_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state_q == ST_IDLE) && cmd_valid && seq_block;
      if ((state_q == ST_HOLD) && (op_q == RD_ADDR)) rd_flag_q <= 1'b1;
      else if (last_rx)                              rd_flag_q <= 1'b0;
    end
  end
`else
  assign seq_block = 1'b0;
  assign err       = 1'b0;
`endif
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: per-cycle SS_n/MOSI/rsp checks against a frame model and slave RAM model.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned RW = 3;
  localparam int unsigned GC = 2;

  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, MISO = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, SS_n, MOSI, rsp_valid, err;
  logic [7:0] rsp_data;

  int checks = 0, failures = 0;

  // Slave-side model: address register + 256-byte RAM; plus master-visible state.
  logic [7:0] mem [256];
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_rsp  = 8'h00;
  bit         m_flag = 1'b0;

  always #5 clk = ~clk;

  spi_master #(.RD_WAIT(RW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  // Issues one command and checks every cycle from acceptance until cmd_ready returns.
  task automatic do_frame(input logic [1:0] op, input logic [7:0] data);
    logic [7:0] miso_byte;
    logic [9:0] frame;
    bit         exp_ss[$];
    bit         exp_mo[$];
    int         total, rv_at;
    bit         e_ss, e_mo;
    miso_byte = mem[m_addr];
    case (op)
      2'b00: m_addr = data;
      2'b01: mem[m_addr] = data;
      2'b10: begin m_addr = data; m_flag = 1'b1; end
      default: m_flag = 1'b0;
    endcase
    frame = {op, (op == 2'b11) ? 8'h00 : data};
    for (int i = 0; i < 2; i++) begin exp_ss.push_back(0); exp_mo.push_back(op[1]); end
    for (int b = 9; b >= 0; b--) begin exp_ss.push_back(0); exp_mo.push_back(frame[b]); end
    if (op != 2'b11) begin exp_ss.push_back(0); exp_mo.push_back(0); end
    else for (int i = 0; i < int'(RW) + 8; i++) begin exp_ss.push_back(0); exp_mo.push_back(0); end
    for (int i = 0; i < int'(GC); i++) begin exp_ss.push_back(1); exp_mo.push_back(0); end
    total = exp_ss.size();
    rv_at = (op == 2'b11) ? 20 + int'(RW) : -1;

    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k <= total; k++) begin
      MISO = (op == 2'b11 && k >= 12 + int'(RW) && k < 20 + int'(RW)) ? miso_byte[k - 12 - int'(RW)] : 1'b0;
      e_ss = (k < total) ? exp_ss[k] : 1'b1;
      e_mo = (k < total) ? exp_mo[k] : 1'b0;
      checks++;
      if (SS_n !== e_ss) begin failures++; $display("FAIL ss_n op=%0d k=%0d: got %b required %b", op, k, SS_n, e_ss); end
      checks++;
      if (MOSI !== e_mo) begin failures++; $display("FAIL mosi op=%0d k=%0d: got %b required %b", op, k, MOSI, e_mo); end
      checks++;
      if (rsp_valid !== (k == rv_at)) begin failures++; $display("FAIL rsp_valid op=%0d k=%0d: got %b required %b", op, k, rsp_valid, k == rv_at); end
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL err op=%0d k=%0d: got %b required 0", op, k, err); end
      checks++;
      if (cmd_ready !== (k == total)) begin failures++; $display("FAIL cmd_ready op=%0d k=%0d: got %b required %b", op, k, cmd_ready, k == total); end
      if (k < total) @(negedge clk);
    end
    MISO = 1'b0;
    if (op == 2'b11) m_rsp = miso_byte;
    checks++;
    if (rsp_data !== m_rsp) begin failures++; $display("FAIL rsp_data op=%0d: got %h required %h", op, rsp_data, m_rsp); end
  endtask

  // With the sequence check enabled, a read-data op needs a completed read-address op first.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
`ifdef SPI_MASTER_SEQ_CHK_EN
    if (op == 2'b11 && !m_flag) do_frame(2'b10, 8'($urandom));
`endif
    do_frame(op, data);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; MISO = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (SS_n !== 1'b1)      begin failures++; $display("FAIL rst_ss_n: got %b required 1", SS_n); end
    checks++; if (MOSI !== 1'b0)      begin failures++; $display("FAIL rst_mosi: got %b required 0", MOSI); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL rst_rsp_data: got %h required 00", rsp_data); end
    checks++; if (err !== 1'b0)       begin failures++; $display("FAIL rst_err: got %b required 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
    m_flag = 1'b0; m_rsp = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_write();
    issue(2'b00, 8'h5A);
  endtask

  task automatic test_read();
    mem[8'h3C] = 8'hA5;
    issue(2'b10, 8'h3C);
    issue(2'b11, 8'h00);
    checks++;
    if (rsp_data !== 8'hA5) begin failures++; $display("FAIL read_a5: got %h required a5", rsp_data); end
  endtask

  task automatic test_e2e();
    issue(2'b00, 8'h10);
    issue(2'b01, 8'h77);
    issue(2'b10, 8'h10);
    issue(2'b11, 8'h00);
    checks++;
    if (rsp_data !== 8'h77) begin failures++; $display("FAIL e2e_77: got %h required 77", rsp_data); end
  endtask

  // Frame period is the frame body, GAP, and the IDLE cycle in which the next command is accepted.
  task automatic test_back_to_back();
    int         period, p;
    bit         e_ss, e_mo;
    logic [9:0] frame;
    period = 14 + int'(GC);
    frame  = {2'b01, 8'hFF};
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3 * period; i++) begin
      p    = i % period;
      e_ss = (p >= 13);
      e_mo = (p >= 2 && p < 12) ? frame[11 - p] : 1'b0;
      checks++;
      if (SS_n !== e_ss) begin failures++; $display("FAIL b2b_ss_n i=%0d: got %b required %b", i, SS_n, e_ss); end
      checks++;
      if (MOSI !== e_mo) begin failures++; $display("FAIL b2b_mosi i=%0d: got %b required %b", i, MOSI, e_mo); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    mem[m_addr] = 8'hFF;
    wait_ready();
  endtask

  task automatic test_seq_chk();
    test_reset();
`ifdef SPI_MASTER_SEQ_CHK_EN
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (err !== 1'b1)       begin failures++; $display("FAIL seq_err_pulse: got %b required 1", err); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL seq_ready: got %b required 1", cmd_ready); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++; if (err !== 1'b0)  begin failures++; $display("FAIL seq_err_once i=%0d: got %b required 0", i, err); end
      checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL seq_ss_n i=%0d: got %b required 1", i, SS_n); end
    end
`else
    do_frame(2'b11, 8'h00);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) issue(2'($urandom_range(0, 3)), 8'($urandom));
  endtask

  task automatic test_reset_mid_frame();
    do_frame(2'b10, 8'($urandom));
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (SS_n !== 1'b0) begin failures++; $display("FAIL mid_in_frame: got %b required 0", SS_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (SS_n !== 1'b1)      begin failures++; $display("FAIL mid_ss_n: got %b required 1", SS_n); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid: got %b required 0", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    m_flag = 1'b0; m_rsp = 8'h00;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_cmd_ready: got %b required 1", cmd_ready); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_rsp i=%0d: got %b required 0", i, rsp_valid); end
      checks++; if (SS_n !== 1'b1)      begin failures++; $display("FAIL mid_idle_ss_n i=%0d: got %b required 1", i, SS_n); end
    end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL mid_rsp_data: got %h required 00", rsp_data); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_e2e();
    test_back_to_back();
    test_seq_chk();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
